load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port. Accepts one load/store request from the execute stage,
//  drives the data memory (mem_we/func_in/func_out/address/data_in, combinational read, write at posedge),
//  and returns the extended load result or store completion. Misaligned accesses are split into byte accesses.
//  Out-of-range or illegal accesses are faulted and never reach the memory.
// PARAMETERS
//  MEM_BYTES  128  bytes of data memory; an access is legal only if address+size-1 < MEM_BYTES
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept a request (high only in IDLE)
//  req_store     in   1   1 = store, 0 = load
//  req_sfunc     in   2   store func: SB=00 SH=01 SW=10 (mem_func.vh)
//  req_lfunc     in   3   load func: LB=000 LH=001 LW=010 LBU=100 LHU=101 (mem_func.vh)
//  req_address   in   32  byte address
//  req_wdata     in   32  store data, byte k = bits [8k+7:8k]
//  resp_valid    out  1   response present; held until resp_ready
//  resp_ready    in   1   consumer takes the response
//  resp_rdata    out  32  extended load data; 0 for stores and faults
//  resp_fault    out  1   illegal func or out-of-range address
//  mem_we        out  1   memory write enable
//  mem_func_in   out  2   store func to memory
//  mem_func_out  out  3   load func to memory
//  mem_address   out  32  memory byte address
//  mem_data_in   out  32  memory write data
//  mem_data_out  in   32  memory read data (combinational in mem_address/mem_func_out)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0,
//   mem_func_in=00, mem_func_out=3'b111 (no-load code, memory returns 0), mem_address=0, mem_data_in=0.
//  Size: SB/LB/LBU=1, SH/LH/LHU=2, SW/LW=4. Aligned: address mod size == 0.
//  FSM IDLE -> (ACCESS | BYTES | RESP) -> RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready latch store/func/address/wdata.
//   Illegal func (sfunc=11, lfunc 011/110/111) or address+size-1 >= MEM_BYTES (33-bit compare, no wrap)
//   -> RESP with resp_fault=1, no memory cycle. Else aligned -> ACCESS; misaligned -> BYTES, k=0.
//  ACCESS (1 cycle): store: mem_we=1, mem_func_in=latched sfunc, mem_data_in=wdata.
//   Load: mem_func_out=LW, mem_address=address & ~3; selected byte/half lane from mem_data_out captured at edge.
//  BYTES (size cycles, k=0..size-1): mem_address=address+k. Store: mem_we=1, mem_func_in=SB,
//   mem_data_in[7:0]=wdata byte k. Load: mem_func_out=LBU, mem_data_out[7:0] captured into result byte k.
//  Loads use only LW and LBU memory codes; sign/zero extension is done here: LB/LH sign-extend from bit 7/15,
//   LBU/LHU zero-extend, LW unchanged.
//  RESP: resp_valid=1, resp_rdata/resp_fault stable; on resp_ready -> IDLE (clears resp_valid; next request
//   accepted one cycle later, no same-cycle turnaround).
//  Outside ACCESS/BYTES: mem_we=0, mem_func_out=3'b111.
//  Latency (accept edge = cycle 0): aligned resp_valid at cycle 2; misaligned at cycle 1+size+1; fault at cycle 1.
//  mem_we is combinational from state, so reset mid-access drops it immediately; writes already clocked
//   remain, remaining bytes of a split store are not written (no rollback).
// TESTING
//  SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_valid 2 cycles after each accept, mem_we 1 cycle.
//  LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  SB 0x55 @0x14, LW @0x11 -> 4 LBU cycles at 0x11..0x14, resp_rdata=0x55DEADBE at cycle 6.
//  SH 0xA5C3 @0x21 -> 2 SB cycles (0x21=C3, 0x22=A5); LHU @0x21 -> 0x0000A5C3; LH @0x21 -> 0xFFFFA5C3.
//  LW @0x7E, SW @0x7C|sfunc=11 (MEM_BYTES=128) -> resp_fault=1, rdata=0 at cycle 1, mem_we never high;
//   SW @0x7C legal.
//  resp_ready low 3 cycles -> resp_valid/rdata held, req_ready=0; reset in 2nd BYTES cycle of SW @0x31
//   -> only 0x31 written, IDLE, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, misaligned accesses split
// into byte cycles, illegal or out-of-range requests faulted before memory.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_sfunc,
  input  logic [2:0]  req_lfunc,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [1:0]  mem_func_in,
  output logic [2:0]  mem_func_out,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_BYTES  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  sfunc_q, sfunc_d;
  logic [2:0]  lfunc_q, lfunc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [2:0]  req_size;
  logic [1:0]  req_mask;
  logic [32:0] req_last;
  logic        req_illegal;
  logic        req_bad;
  logic        req_aligned;
  logic [31:0] lane;
  logic [7:0]  wbyte;

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] r);
    logic [31:0] v;
    case (f)
      3'b000:  v = {{24{r[7]}}, r[7:0]};
      3'b001:  v = {{16{r[15]}}, r[15:0]};
      3'b100:  v = {24'd0, r[7:0]};
      3'b101:  v = {16'd0, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  always_comb begin
    req_size = 3'd4;
    if (req_store) begin
      if (req_sfunc == 2'b00) req_size = 3'd1;
      else if (req_sfunc == 2'b01) req_size = 3'd2;
    end else begin
      if (req_lfunc[1:0] == 2'b00) req_size = 3'd1;
      else if (req_lfunc[1:0] == 2'b01) req_size = 3'd2;
    end
  end

  // 33-bit end address so requests near 2^32 cannot wrap into range
  assign req_last = {1'b0, req_address} + {30'd0, req_size} - 33'd1;
  assign req_illegal = req_store ? (req_sfunc == 2'b11)
                     : (req_lfunc == 3'b011 || req_lfunc[2:1] == 2'b11);
  assign req_bad = req_illegal || (req_last >= 33'(MEM_BYTES));
  assign req_mask = req_size[1:0] - 2'd1;
  assign req_aligned = (req_address[1:0] & req_mask) == 2'b00;

  assign lane  = mem_data_out >> {addr_q[1:0], 3'b000};
  assign wbyte = 8'(wdata_q >> {k_q[1:0], 3'b000});

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    sfunc_d = sfunc_q;
    lfunc_d = lfunc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    k_d     = k_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          sfunc_d = req_sfunc;
          lfunc_d = req_lfunc;
          addr_d  = req_address;
          wdata_d = req_wdata;
          size_d  = req_size;
          k_d     = 3'd0;
          rdata_d = 32'd0;
          fault_d = req_bad;
          if (req_bad) state_d = S_RESP;
          else if (req_aligned) state_d = S_ACCESS;
          else state_d = S_BYTES;
        end
      end
      S_ACCESS: begin
        if (!store_q) rdata_d = ext(lfunc_q, lane);
        state_d = S_RESP;
      end
      S_BYTES: begin
        // extra cycle after the last byte applies the extension
        if (k_q == size_q) begin
          rdata_d = ext(lfunc_q, rdata_q);
          state_d = S_RESP;
        end else begin
          k_d = k_q + 3'd1;
          if (!store_q)
            rdata_d = rdata_q
                    | ({24'd0, mem_data_out[7:0]} << {k_q[1:0], 3'b000});
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we       = 1'b0;
    mem_func_in  = 2'b00;
    mem_func_out = 3'b111;
    mem_address  = 32'd0;
    mem_data_in  = 32'd0;
    if (state_q == S_ACCESS) begin
      if (store_q) begin
        mem_we      = 1'b1;
        mem_func_in = sfunc_q;
        mem_address = addr_q;
        mem_data_in = wdata_q;
      end else begin
        mem_func_out = 3'b010;
        mem_address  = {addr_q[31:2], 2'b00};
      end
    end else if (state_q == S_BYTES && k_q != size_q) begin
      mem_address = addr_q + {29'd0, k_q};
      if (store_q) begin
        mem_we      = 1'b1;
        mem_data_in = {24'd0, wbyte};
      end else begin
        mem_func_out = 3'b100;
      end
    end
  end

  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      sfunc_q <= 2'b00;
      lfunc_q <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 3'd0;
      k_q     <= 3'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      sfunc_q <= sfunc_d;
      lfunc_q <= lfunc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      k_q     <= k_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, directed cases and random
// requests scored against a byte-level reference memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_sfunc;
  logic [2:0]  req_lfunc;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [1:0]  mem_func_in;
  logic [2:0]  mem_func_out;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [7:0] mem [0:127];
  logic [7:0] refm [0:127];
  logic       init_mem;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_sfunc(req_sfunc),
    .req_lfunc(req_lfunc), .req_address(req_address),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_func_in(mem_func_in),
    .mem_func_out(mem_func_out), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always_comb begin
    mem_data_out = 32'd0;
    if (mem_func_out == 3'b010) begin
      for (int i = 0; i < 4; i++)
        if (mem_address + 32'(i) < 32'd128)
          mem_data_out[8*i +: 8] = mem[7'(mem_address + 32'(i))];
    end else if (mem_func_out == 3'b100) begin
      if (mem_address < 32'd128)
        mem_data_out = {24'd0, mem[7'(mem_address)]};
    end
  end

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (i < (mem_func_in == 2'b00 ? 1 : mem_func_in == 2'b01 ? 2 : 4)
            && mem_address + 32'(i) < 32'd128)
          mem[7'(mem_address + 32'(i))] <= mem_data_in[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"},
        {req_ready, resp_valid, resp_fault, mem_we, mem_func_in, mem_func_out},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111});
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_din"}, mem_data_in, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
  endtask

  task automatic do_req(input logic st, input logic [1:0] sf,
                        input logic [2:0] lf, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] got);
    int sz, exp_lat, exp_we, lat, wecnt, w;
    logic bad;
    logic [32:0] last;
    logic [31:0] raw, exp_d;
    sz = st ? (sf == 2'b00 ? 1 : sf == 2'b01 ? 2 : 4)
            : (lf[1:0] == 2'b00 ? 1 : lf[1:0] == 2'b01 ? 2 : 4);
    bad = st ? (sf == 2'b11) : (lf == 3'b011 || lf == 3'b110 || lf == 3'b111);
    last = {1'b0, a} + 33'(sz) - 33'd1;
    if (last >= 33'd128) bad = 1'b1;
    exp_d = 0;
    exp_we = 0;
    if (bad) exp_lat = 1;
    else if (a % 32'(sz) == 0) exp_lat = 2;
    else exp_lat = sz + 2;
    if (!bad && st) begin
      for (int i = 0; i < sz; i++) refm[7'(a + 32'(i))] = wd[8*i +: 8];
      exp_we = (a % 32'(sz) == 0) ? 1 : sz;
    end else if (!bad) begin
      raw = 0;
      for (int i = 0; i < sz; i++) raw[8*i +: 8] = refm[7'(a + 32'(i))];
      case (lf)
        3'b000:  exp_d = 32'(signed'(raw[7:0]));
        3'b001:  exp_d = 32'(signed'(raw[15:0]));
        3'b100:  exp_d = 32'(raw[7:0]);
        3'b101:  exp_d = 32'(raw[15:0]);
        default: exp_d = raw;
      endcase
    end
    @(negedge clock);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clock);
      w++;
    end
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_store = st;
    req_sfunc = sf;
    req_lfunc = lf;
    req_address = a;
    req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_address = $urandom;
    req_wdata = $urandom;
    lat = 1;
    wecnt = 0;
    while (!resp_valid && lat < 40) begin
      if (mem_we) wecnt++;
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rdata", resp_rdata, exp_d);
    chk("fault", resp_fault, bad);
    chk("we_cycles", wecnt, exp_we);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold", {resp_valid, req_ready, resp_rdata}, {1'b1, 1'b0, exp_d});
    end
    got = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    chk("to_idle", {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] g;
    logic [2:0] lf_tab [0:7];
    int mism;
    lf_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
               3'b010, 3'b011, 3'b111};
    reset = 1'b1;
    init_mem = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_sfunc = 2'b00;
    req_lfunc = 3'b000;
    req_address = 0;
    req_wdata = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 128; i++) refm[i] = 8'(i * 37 + 11);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset("reset");
    init_mem = 1'b0;
    reset = 1'b0;

    do_req(1, 2'b10, 3'b000, 32'h10, 32'hDEADBEEF, 0, g);
    do_req(0, 2'b00, 3'b010, 32'h10, 0, 0, g);
    chk("lw10", g, 32'hDEADBEEF);
    do_req(0, 2'b00, 3'b000, 32'h13, 0, 0, g);
    chk("lb13", g, 32'hFFFFFFDE);
    do_req(0, 2'b00, 3'b100, 32'h13, 0, 0, g);
    chk("lbu13", g, 32'h000000DE);
    do_req(0, 2'b00, 3'b001, 32'h12, 0, 0, g);
    chk("lh12", g, 32'hFFFFDEAD);
    do_req(0, 2'b00, 3'b101, 32'h10, 0, 0, g);
    chk("lhu10", g, 32'h0000BEEF);
    do_req(1, 2'b00, 3'b000, 32'h14, 32'h55, 0, g);
    do_req(0, 2'b00, 3'b010, 32'h11, 0, 3, g);
    chk("lw11", g, 32'h55DEADBE);
    do_req(1, 2'b01, 3'b000, 32'h21, 32'hA5C3, 0, g);
    do_req(0, 2'b00, 3'b101, 32'h21, 0, 0, g);
    chk("lhu21", g, 32'h0000A5C3);
    do_req(0, 2'b00, 3'b001, 32'h21, 0, 0, g);
    chk("lh21", g, 32'hFFFFA5C3);
    do_req(0, 2'b00, 3'b010, 32'h7E, 0, 0, g);
    do_req(1, 2'b11, 3'b000, 32'h7C, 32'h12345678, 0, g);
    do_req(1, 2'b10, 3'b000, 32'h7C, 32'hCAFEF00D, 0, g);
    do_req(0, 2'b00, 3'b010, 32'hFFFFFFFE, 0, 0, g);

    // reset during the second byte cycle of a split store
    @(negedge clock);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_sfunc = 2'b10;
    req_address = 32'h31;
    req_wdata = 32'h11223344;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset("midreset");
    refm[7'h31] = 8'h44;
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic st;
      logic [1:0] sf;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      sf = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 135));
      do_req(st, sf, lf_tab[$urandom_range(0, 7)], a, $urandom,
             $urandom_range(0, 2), g);
    end

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== refm[i]) mism++;
    chk("mem_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
